pwm_phase_loader: RTL and testbench
===================================

// Module: pwm_phase_loader
// PURPOSE
//  Double-buffered configuration controller for the per-channel PWM phase/enable table.
//  Host-side logic streams (channel, phase, enable) writes into a shadow bank.
//  A commit request copies the whole shadow bank into the active bank in one atomic
//  update, aligned to the PWM controller's cycleStart. Mid-period phase glitches
//  on the transducer outputs therefore cannot occur.
//  Sits between the host/UART command decoder and the PWM controller's phase/en inputs.
// PARAMETERS
//  NUM_CHANNELS  16          number of PWM channels
//  CLK_FREQ      50_000_000  system clock in Hz
//  OUT_FREQ      40_000      PWM output frequency in Hz
//  (derived) CNT_MAX = CLK_FREQ/OUT_FREQ
//  (derived) PHASE_W = $clog2(CNT_MAX)
//  (derived) CH_W    = $clog2(NUM_CHANNELS), minimum 1
// PORTS
//  clk          in   1        system clock; all logic on posedge
//  nReset       in   1        asynchronous reset, active-low
//  wr_valid     in   1        write request
//  wr_ready     out  1        controller can accept a write
//  wr_chan      in   CH_W     target channel index
//  wr_phase     in   PHASE_W  phase offset in clock counts
//  wr_en        in   1        channel enable
//  wr_err       out  1        one-cycle pulse: last accepted write was rejected
//  commit       in   1        request shadow->active copy (level, sampled per cycle)
//  cycleStart   in   1        from PWM controller; high 2 clocks before the period boundary
//  phase        out  PHASE_W x NUM_CHANNELS  active phase table, unpacked array
//  en           out  1 x NUM_CHANNELS        active enable table, unpacked array
//  pending      out  1        commit accepted, waiting for cycleStart
//  commit_done  out  1        one-cycle pulse: active bank updated this cycle
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - active and shadow banks: phase=0, en=0
//   - state=IDLE
//   - wr_ready=0, wr_err=0, pending=0, commit_done=0
//   - wr_ready is registered; it rises on the first clk edge after nReset deasserts
//   - Reset mid-operation discards shadow contents and any pending commit
//  FSM:
//   - IDLE: wr_ready=1. commit=1 -> PENDING on next edge
//       (applies even if cycleStart=1 in the same cycle; that cycleStart is NOT used).
//   - PENDING: wr_ready=0, pending=1. On the edge where cycleStart=1:
//       active <= shadow for all channels at once, commit_done=1 for the next cycle,
//       state -> IDLE. commit is ignored while PENDING; no queueing.
//  Write handshake:
//   - A write transfers on an edge with wr_valid && wr_ready.
//   - It updates shadow[wr_chan] <= {wr_phase, wr_en} only if wr_chan < NUM_CHANNELS
//     and wr_phase < CNT_MAX.
//   - Otherwise shadow is unchanged and wr_err pulses for one cycle after the edge.
//   - Repeated writes to the same channel before a commit: last write wins.
//   - A write and commit in the same IDLE cycle: the write is included in that commit.
//  Active bank:
//   - Changes only on a commit edge. phase/en are registered outputs, stable for a
//     full PWM period.
//   - New values are visible 1 clock before the PWM period boundary.
//   - Commit with no intervening writes re-copies an identical shadow (legal no-op,
//     commit_done still pulses).
//  Latency:
//   - commit high at cycle t -> active updated at the first cycleStart edge strictly after t.
//   - Worst case is one full PWM period plus 1 clock.
//  Missing cycleStart (PWM held in reset): stays PENDING indefinitely.
// TESTING (NUM_CHANNELS=4, CLK_FREQ=1000, OUT_FREQ=10 -> CNT_MAX=100, PHASE_W=7)
//  1. Reset, release
//     -> phase[0..3]=0, en=0; wr_ready=0 then 1 one clock later; pending=0.
//  2. Write ch2 phase=37 en=1, commit, cycleStart 20 clocks later
//     -> phase[2]=37, en[2]=1 one clock after the cycleStart edge; commit_done 1 cycle;
//        other channels 0.
//  3. Write ch1 phase=100 (>=CNT_MAX), then phase=99
//     -> first: wr_err pulse, shadow unchanged; second accepted, visible after commit.
//  4. commit and cycleStart high in the same IDLE cycle
//     -> no update at that cycleStart; update at the next cycleStart 100 clocks later.
//  5. While PENDING: wr_valid held, second commit pulse
//     -> wr_ready=0, no transfer, single commit_done. Write transfers the cycle after
//        return to IDLE.
//  6. Assert nReset while PENDING with shadow ch0=50
//     -> all outputs return to reset values immediately. No commit_done after release.

Source files
------------

// File: rtl/pwm_phase_loader.sv
// Double-buffered PWM phase/enable table. Host writes go into a shadow bank.
// A commit copies the shadow bank into the active bank in one step, on the next cycleStart.
module pwm_phase_loader #(
  parameter  int NUM_CHANNELS = 16,
  parameter  int CLK_FREQ     = 50_000_000,
  parameter  int OUT_FREQ     = 40_000,
  localparam int CNT_MAX      = CLK_FREQ / OUT_FREQ,
  localparam int PHASE_W      = $clog2(CNT_MAX),
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CH_W-1:0]    wr_chan,
  input  logic [PHASE_W-1:0] wr_phase,
  input  logic               wr_en,
  output logic               wr_err,
  input  logic               commit,
  input  logic               cycleStart,
  output logic [PHASE_W-1:0] phase [NUM_CHANNELS],
  output logic               en [NUM_CHANNELS],
  output logic               pending,
  output logic               commit_done
);

  typedef enum logic {IDLE, PENDING} stateT;

  stateT              state;
  stateT              nextState;
  logic [PHASE_W-1:0] shadowPhase [NUM_CHANNELS];
  logic               shadowEn [NUM_CHANNELS];
  logic               chanOk;
  logic               phaseOk;
  logic               wrFire;
  logic               wrLegal;
  logic               doCommit;

  // A range check is only built where the field can actually hold an illegal value.
  generate
    if ((2 ** CH_W) > NUM_CHANNELS) begin : gChanCheck
      assign chanOk = int'(wr_chan) < NUM_CHANNELS;
    end else begin : gChanAll
      assign chanOk = 1'b1;
    end
    if ((2 ** PHASE_W) > CNT_MAX) begin : gPhaseCheck
      assign phaseOk = int'(wr_phase) < CNT_MAX;
    end else begin : gPhaseAll
      assign phaseOk = 1'b1;
    end
  endgenerate

  assign wrFire  = wr_valid && wr_ready;
  assign wrLegal = chanOk && phaseOk;
  assign pending = (state == PENDING);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A commit seen in IDLE arms the copy; only a cycleStart seen while PENDING can fire it.
  always_comb begin
    nextState = state;
    doCommit  = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          nextState = PENDING;
        end
      end
      PENDING: begin
        if (cycleStart) begin
          doCommit  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ready    <= 1'b0;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      wr_ready    <= (nextState == IDLE);
      wr_err      <= wrFire && !wrLegal;
      commit_done <= doCommit;
    end
  end

  // Writes and commits never share an edge: wr_ready is low for the whole PENDING state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadowPhase[i] <= '0;
        shadowEn[i]    <= 1'b0;
        phase[i]       <= '0;
        en[i]          <= 1'b0;
      end
    end else begin
      if (wrFire && wrLegal) begin
        shadowPhase[wr_chan] <= wr_phase;
        shadowEn[wr_chan]    <= wr_en;
      end
      if (doCommit) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          phase[i] <= shadowPhase[i];
          en[i]    <= shadowEn[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_phase_loader.sv
// Bench for pwm_phase_loader: directed scenarios followed by random traffic,
// with every output compared against a transaction-level model after each clock.
module tb_pwm_phase_loader;

  localparam int NCH    = 4;
  localparam int CNTMAX = 100;

  logic       clk = 1'b0;
  logic       nReset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_chan;
  logic [6:0] wr_phase;
  logic       wr_en;
  logic       wr_err;
  logic       commit;
  logic       cycleStart;
  logic [6:0] phase [NCH];
  logic       en [NCH];
  logic       pending;
  logic       commit_done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: two banks plus a "commit armed" flag and the output pulses.
  int mShPhase  [NCH];
  int mShEn     [NCH];
  int mActPhase [NCH];
  int mActEn    [NCH];
  bit mPending;
  bit mReady;
  bit mErr;
  bit mDone;

  always #5 clk = ~clk;

  pwm_phase_loader #(
    .NUM_CHANNELS(NCH),
    .CLK_FREQ(1000),
    .OUT_FREQ(10)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_chan(wr_chan),
    .wr_phase(wr_phase),
    .wr_en(wr_en),
    .wr_err(wr_err),
    .commit(commit),
    .cycleStart(cycleStart),
    .phase(phase),
    .en(en),
    .pending(pending),
    .commit_done(commit_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".wr_ready"}, 32'(wr_ready), 32'(mReady));
    checkOutput({tag, ".pending"}, 32'(pending), 32'(mPending));
    checkOutput({tag, ".commit_done"}, 32'(commit_done), 32'(mDone));
    checkOutput({tag, ".wr_err"}, 32'(wr_err), 32'(mErr));
    for (int i = 0; i < NCH; i++) begin
      checkOutput($sformatf("%s.phase%0d", tag, i), 32'(phase[i]), 32'(mActPhase[i]));
      checkOutput($sformatf("%s.en%0d", tag, i), 32'(en[i]), 32'(mActEn[i]));
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NCH; i++) begin
      mShPhase[i]  = 0;
      mShEn[i]     = 0;
      mActPhase[i] = 0;
      mActEn[i]    = 0;
    end
    mPending = 0;
    mReady   = 0;
    mErr     = 0;
    mDone    = 0;
  endtask

  // Drive one cycle of inputs, let the clock edge happen, advance the model, then compare.
  task automatic applyStimulus(input bit v, input int ch, input int ph, input bit e,
                               input bit cm, input bit cs, input string tag);
    bit accepted;
    bit legal;
    wr_valid   = v;
    wr_chan    = ch[1:0];
    wr_phase   = ph[6:0];
    wr_en      = e;
    commit     = cm;
    cycleStart = cs;
    @(posedge clk);
    accepted = v && mReady;
    legal    = (ch < NCH) && (ph < CNTMAX);
    mErr     = accepted && !legal;
    mDone    = mPending && cs;
    if (mDone) begin
      for (int i = 0; i < NCH; i++) begin
        mActPhase[i] = mShPhase[i];
        mActEn[i]    = mShEn[i];
      end
    end
    if (accepted && legal) begin
      mShPhase[ch] = ph;
      mShEn[ch]    = int'(e);
    end
    mPending = mPending ? !cs : cm;
    mReady   = !mPending;
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, tag);
    end
  endtask

  initial begin
    nReset     = 1'b0;
    wr_valid   = 1'b0;
    wr_chan    = '0;
    wr_phase   = '0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    cycleStart = 1'b0;
    resetModel();

    // Reset state, then wr_ready rising one clock after release.
    #2;
    checkAll("t1_inReset");
    @(posedge clk);
    #1;
    nReset = 1'b1;
    #1;
    checkAll("t1_released");
    idleCycles(1, "t1_ready");
    checkOutput("t1_readyHigh", 32'(wr_ready), 32'd1);

    // Single write, commit, cycleStart twenty clocks later.
    applyStimulus(1, 2, 37, 1, 0, 0, "t2_write");
    applyStimulus(0, 0, 0, 0, 1, 0, "t2_commit");
    idleCycles(19, "t2_wait");
    checkOutput("t2_notYet", 32'(phase[2]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, "t2_cycleStart");
    checkOutput("t2_phase2", 32'(phase[2]), 32'd37);
    checkOutput("t2_en2", 32'(en[2]), 32'd1);
    checkOutput("t2_done", 32'(commit_done), 32'd1);
    idleCycles(1, "t2_after");
    checkOutput("t2_doneOnce", 32'(commit_done), 32'd0);

    // Out-of-range phase rejected, boundary value CNT_MAX-1 accepted.
    applyStimulus(1, 1, 100, 1, 0, 0, "t3_bad");
    checkOutput("t3_err", 32'(wr_err), 32'd1);
    applyStimulus(1, 1, 99, 1, 0, 0, "t3_good");
    checkOutput("t3_noErr", 32'(wr_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, "t3_commit");
    applyStimulus(0, 0, 0, 0, 0, 1, "t3_cycleStart");
    checkOutput("t3_phase1", 32'(phase[1]), 32'd99);

    // commit and cycleStart together: that cycleStart must not fire the copy.
    applyStimulus(1, 0, 12, 1, 0, 0, "t4_write");
    applyStimulus(0, 0, 0, 0, 1, 1, "t4_both");
    idleCycles(99, "t4_wait");
    checkOutput("t4_noEarly", 32'(phase[0]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, "t4_cycleStart");
    checkOutput("t4_phase0", 32'(phase[0]), 32'd12);

    // Held write and second commit while PENDING.
    applyStimulus(0, 0, 0, 0, 1, 0, "t5_commit");
    applyStimulus(1, 3, 55, 1, 0, 0, "t5_held");
    checkOutput("t5_notReady", 32'(wr_ready), 32'd0);
    applyStimulus(1, 3, 55, 1, 1, 0, "t5_commit2");
    applyStimulus(1, 3, 55, 1, 0, 1, "t5_cycleStart");
    checkOutput("t5_phase3Old", 32'(phase[3]), 32'd0);
    applyStimulus(1, 3, 55, 1, 0, 0, "t5_transfer");
    applyStimulus(0, 0, 0, 0, 0, 1, "t5_noSecondDone");
    checkOutput("t5_singleDone", 32'(commit_done), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, "t5_commit3");
    applyStimulus(0, 0, 0, 0, 0, 1, "t5_cycleStart2");
    checkOutput("t5_phase3", 32'(phase[3]), 32'd55);

    // Reset while PENDING discards shadow and the armed commit.
    applyStimulus(1, 0, 50, 1, 0, 0, "t6_write");
    applyStimulus(0, 0, 0, 0, 1, 0, "t6_commit");
    idleCycles(2, "t6_pending");
    #2;
    nReset = 1'b0;
    resetModel();
    #1;
    checkAll("t6_async");
    checkOutput("t6_phase0Cleared", 32'(phase[0]), 32'd0);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    #1;
    checkAll("t6_released");
    applyStimulus(0, 0, 0, 0, 0, 1, "t6_cycleStart");
    checkOutput("t6_noDone", 32'(commit_done), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, "t6_commit2");
    applyStimulus(0, 0, 0, 0, 0, 1, "t6_cycleStart2");
    checkOutput("t6_shadowLost", 32'(phase[0]), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, NCH - 1)),
                    int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
